// File: rtl/fpga_tg_cfg_regfile.sv
// -----------------------------------------------------------------------------
// fpga_picobello_pkg / fpga_tg_cfg_regfile
//
// Purpose: AXI4-Lite slave register file, driven by the FPGA host. It keeps one
// tg_cfg_t per traffic generator, issues one-cycle start pulses, and collects
// per-generator busy / sticky-done status so the host can poll completion.
//
// Channel handshake: a beat transfers on a rising clk_i edge where both valid
// and ready are high; a source holds valid and payload stable until that edge.
// Ready may be asserted before valid. Responses (bvalid/rvalid) stay high with
// a stable payload until the matching ready is seen at a clock edge.
//
// Ports:
//   clk_i          clock
//   rst_i          synchronous reset, active-high
//   axi_lite_req_i host AXI4-Lite request (32b address / data)
//   axi_lite_rsp_o host AXI4-Lite response
//   tg_cfg_o       per-generator configuration, registered
//   tg_start_o     one-cycle start pulse per generator
//   tg_busy_i      generator running
//   tg_done_i      one-cycle completion pulse per generator
//
// Bank layout (32b registers, 64b fields split lo/hi):
//   0x00 PORT_IDS [3:0] traffic_gen_port_id, [7:4] mem_port_id
//   0x08/0x0C TG_BASE   0x10/0x14 MEM_BASE   0x18/0x1C TRAFFIC_DIM
//   0x20/0x24 COMPUTE_DIM   0x28/0x2C IDX
//   0x30 CTRL   write bit0=1 starts the generator, reads 0
//   0x34 STATUS bit0 busy (RO), bit1 sticky done (W1C)
// -----------------------------------------------------------------------------
package fpga_picobello_pkg;

   localparam int unsigned NumTrafficGenerators = 3;

   typedef struct packed {
      logic [31:0] aw_addr;
      logic        aw_valid;
      logic [31:0] w_data;
      logic [3:0]  w_strb;
      logic        w_valid;
      logic        b_ready;
      logic [31:0] ar_addr;
      logic        ar_valid;
      logic        r_ready;
   } axi_lite_host_req_t;

   typedef struct packed {
      logic        aw_ready;
      logic        w_ready;
      logic [1:0]  b_resp;
      logic        b_valid;
      logic        ar_ready;
      logic [31:0] r_data;
      logic [1:0]  r_resp;
      logic        r_valid;
   } axi_lite_host_rsp_t;

   typedef struct packed {
      logic [3:0]  traffic_gen_port_id;
      logic [3:0]  mem_port_id;
      logic [63:0] traffic_gen_addr_base;
      logic [63:0] mem_addr_base;
      logic [63:0] traffic_dim;
      logic [63:0] compute_dim;
      logic [63:0] idx;
   } tg_cfg_t;

   typedef enum logic { W_IDLE, W_RESP } wr_state_e;
   typedef enum logic { R_IDLE, R_RESP } rd_state_e;

endpackage

module fpga_tg_cfg_regfile
   import fpga_picobello_pkg::*;
#(
   parameter int unsigned NumTg      = fpga_picobello_pkg::NumTrafficGenerators,
   parameter int unsigned BankStride = 32'h40
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  axi_lite_host_req_t           axi_lite_req_i,
   output axi_lite_host_rsp_t           axi_lite_rsp_o,
   output tg_cfg_t [NumTg-1:0]          tg_cfg_o,
   output logic    [NumTg-1:0]          tg_start_o,
   input  logic    [NumTg-1:0]          tg_busy_i,
   input  logic    [NumTg-1:0]          tg_done_i
);

   localparam int unsigned OffW     = $clog2(BankStride);
   localparam int unsigned IdxW     = (NumTg > 1) ? $clog2(NumTg) : 1;
   localparam int unsigned NumSlots = 1 << IdxW;

   localparam logic [1:0] RespOkay   = 2'b00;
   localparam logic [1:0] RespSlverr = 2'b10;

   typedef logic [IdxW-1:0] bank_t;

   typedef enum logic [3:0] {
      RS_PORT, RS_TG_LO, RS_TG_HI, RS_MEM_LO, RS_MEM_HI, RS_TD_LO, RS_TD_HI,
      RS_CD_LO, RS_CD_HI, RS_IDX_LO, RS_IDX_HI, RS_CTRL, RS_STATUS, RS_NONE
   } reg_sel_e;

   // word is the 32b register index inside a bank (byte offset / 4)
   function automatic reg_sel_e decode_sel(input int unsigned word);
      reg_sel_e sel;
      case (word)
         0:       sel = RS_PORT;
         2:       sel = RS_TG_LO;
         3:       sel = RS_TG_HI;
         4:       sel = RS_MEM_LO;
         5:       sel = RS_MEM_HI;
         6:       sel = RS_TD_LO;
         7:       sel = RS_TD_HI;
         8:       sel = RS_CD_LO;
         9:       sel = RS_CD_HI;
         10:      sel = RS_IDX_LO;
         11:      sel = RS_IDX_HI;
         12:      sel = RS_CTRL;
         13:      sel = RS_STATUS;
         default: sel = RS_NONE;
      endcase
      return sel;
   endfunction

   function automatic logic [31:0] merge(input logic [31:0] old_v,
                                         input logic [31:0] new_v,
                                         input logic [3:0]  strb);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = strb[i] ? new_v[i*8 +: 8] : old_v[i*8 +: 8];
      end
      return res;
   endfunction

   // ---------------------------------------------------------------- state
   wr_state_e               wr_state_q;
   logic                    aw_held_q, w_held_q;
   logic [31:0]             aw_addr_q, w_data_q;
   logic [3:0]              w_strb_q;
   logic [1:0]              bresp_q;
   rd_state_e               rd_state_q;
   logic [31:0]             rdata_q;
   logic [1:0]              rresp_q;
   tg_cfg_t [NumTg-1:0]     cfg_q, cfg_d;
   logic    [NumTg-1:0]     start_q, start_d;
   logic    [NumTg-1:0]     done_q, done_d, done_clr;

   // Busy padded to a power of two so any decoded bank index selects safely.
   logic [NumSlots-1:0]     busy_pad;
   assign busy_pad = NumSlots'(tg_busy_i);

   // ---------------------------------------------------------- write decode
   logic        aw_fire, w_fire, commit;
   logic [31:0] wr_addr, wr_data;
   logic [3:0]  wr_strb;
   bank_t       wr_bank;
   logic        wr_bank_ok, wr_cfg, wr_busy, wr_start, wr_err, wr_ok;
   reg_sel_e    wr_sel;

   always_comb begin
      aw_fire    = (wr_state_q == W_IDLE) && !aw_held_q && axi_lite_req_i.aw_valid;
      w_fire     = (wr_state_q == W_IDLE) && !w_held_q  && axi_lite_req_i.w_valid;
      // AW and W may land in either order; commit once both are available.
      commit     = (wr_state_q == W_IDLE) && (aw_held_q || aw_fire) && (w_held_q || w_fire);
      wr_addr    = aw_held_q ? aw_addr_q : axi_lite_req_i.aw_addr;
      wr_data    = w_held_q  ? w_data_q  : axi_lite_req_i.w_data;
      wr_strb    = w_held_q  ? w_strb_q  : axi_lite_req_i.w_strb;
      wr_bank    = wr_addr[OffW +: IdxW];
      wr_bank_ok = 32'(wr_bank) < NumTg;
      wr_sel     = decode_sel(32'(wr_addr[OffW-1:2]));
      wr_cfg     = (wr_sel != RS_CTRL) && (wr_sel != RS_STATUS) && (wr_sel != RS_NONE);
      wr_busy    = busy_pad[wr_bank];
      wr_start   = (wr_sel == RS_CTRL) && wr_strb[0] && wr_data[0];
      wr_err     = !wr_bank_ok || (wr_sel == RS_NONE) || ((wr_cfg || wr_start) && wr_busy);
      wr_ok      = commit && !wr_err;
   end

   // ------------------------------------------------------ register update
   always_comb begin
      cfg_d    = cfg_q;
      start_d  = '0;
      done_clr = '0;
      for (int b = 0; b < NumTg; b++) begin
         if (wr_ok && (wr_bank == bank_t'(b))) begin
            case (wr_sel)
               RS_PORT: begin
                  if (wr_strb[0]) begin
                     cfg_d[b].traffic_gen_port_id = wr_data[3:0];
                     cfg_d[b].mem_port_id         = wr_data[7:4];
                  end
               end
               RS_TG_LO:  cfg_d[b].traffic_gen_addr_base[31:0]  = merge(cfg_q[b].traffic_gen_addr_base[31:0],  wr_data, wr_strb);
               RS_TG_HI:  cfg_d[b].traffic_gen_addr_base[63:32] = merge(cfg_q[b].traffic_gen_addr_base[63:32], wr_data, wr_strb);
               RS_MEM_LO: cfg_d[b].mem_addr_base[31:0]          = merge(cfg_q[b].mem_addr_base[31:0],          wr_data, wr_strb);
               RS_MEM_HI: cfg_d[b].mem_addr_base[63:32]         = merge(cfg_q[b].mem_addr_base[63:32],         wr_data, wr_strb);
               RS_TD_LO:  cfg_d[b].traffic_dim[31:0]            = merge(cfg_q[b].traffic_dim[31:0],            wr_data, wr_strb);
               RS_TD_HI:  cfg_d[b].traffic_dim[63:32]           = merge(cfg_q[b].traffic_dim[63:32],           wr_data, wr_strb);
               RS_CD_LO:  cfg_d[b].compute_dim[31:0]            = merge(cfg_q[b].compute_dim[31:0],            wr_data, wr_strb);
               RS_CD_HI:  cfg_d[b].compute_dim[63:32]           = merge(cfg_q[b].compute_dim[63:32],           wr_data, wr_strb);
               RS_IDX_LO: cfg_d[b].idx[31:0]                    = merge(cfg_q[b].idx[31:0],                    wr_data, wr_strb);
               RS_IDX_HI: cfg_d[b].idx[63:32]                   = merge(cfg_q[b].idx[63:32],                   wr_data, wr_strb);
               RS_CTRL: begin
                  if (wr_start) begin
                     start_d[b]  = 1'b1;
                     done_clr[b] = 1'b1;
                  end
               end
               RS_STATUS: begin
                  if (wr_strb[0] && wr_data[1]) done_clr[b] = 1'b1;
               end
               default: ;
            endcase
         end
      end
      // A completion pulse in the same cycle as a clear must not be lost.
      done_d = (done_q & ~done_clr) | tg_done_i;
   end

   // ---------------------------------------------------------- write FSM
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wr_state_q <= W_IDLE;
         aw_held_q  <= 1'b0;
         w_held_q   <= 1'b0;
         aw_addr_q  <= '0;
         w_data_q   <= '0;
         w_strb_q   <= '0;
         bresp_q    <= RespOkay;
         cfg_q      <= '0;
         start_q    <= '0;
         done_q     <= '0;
      end else begin
         cfg_q   <= cfg_d;
         start_q <= start_d;
         done_q  <= done_d;
         case (wr_state_q)
            W_IDLE: begin
               if (commit) begin
                  aw_held_q  <= 1'b0;
                  w_held_q   <= 1'b0;
                  bresp_q    <= wr_err ? RespSlverr : RespOkay;
                  wr_state_q <= W_RESP;
               end else begin
                  if (aw_fire) begin
                     aw_held_q <= 1'b1;
                     aw_addr_q <= axi_lite_req_i.aw_addr;
                  end
                  if (w_fire) begin
                     w_held_q <= 1'b1;
                     w_data_q <= axi_lite_req_i.w_data;
                     w_strb_q <= axi_lite_req_i.w_strb;
                  end
               end
            end
            W_RESP: begin
               if (axi_lite_req_i.b_ready) wr_state_q <= W_IDLE;
            end
            default: wr_state_q <= W_IDLE;
         endcase
      end
   end

   // ----------------------------------------------------------- read path
   bank_t       rd_bank;
   logic        rd_bank_ok, rd_err;
   reg_sel_e    rd_sel;
   logic [31:0] rd_data;

   always_comb begin
      rd_bank    = axi_lite_req_i.ar_addr[OffW +: IdxW];
      rd_bank_ok = 32'(rd_bank) < NumTg;
      rd_sel     = decode_sel(32'(axi_lite_req_i.ar_addr[OffW-1:2]));
      rd_err     = !rd_bank_ok || (rd_sel == RS_NONE);
      rd_data    = '0;
      for (int b = 0; b < NumTg; b++) begin
         if (rd_bank == bank_t'(b)) begin
            case (rd_sel)
               RS_PORT:   rd_data = {24'h0, cfg_q[b].mem_port_id, cfg_q[b].traffic_gen_port_id};
               RS_TG_LO:  rd_data = cfg_q[b].traffic_gen_addr_base[31:0];
               RS_TG_HI:  rd_data = cfg_q[b].traffic_gen_addr_base[63:32];
               RS_MEM_LO: rd_data = cfg_q[b].mem_addr_base[31:0];
               RS_MEM_HI: rd_data = cfg_q[b].mem_addr_base[63:32];
               RS_TD_LO:  rd_data = cfg_q[b].traffic_dim[31:0];
               RS_TD_HI:  rd_data = cfg_q[b].traffic_dim[63:32];
               RS_CD_LO:  rd_data = cfg_q[b].compute_dim[31:0];
               RS_CD_HI:  rd_data = cfg_q[b].compute_dim[63:32];
               RS_IDX_LO: rd_data = cfg_q[b].idx[31:0];
               RS_IDX_HI: rd_data = cfg_q[b].idx[63:32];
               RS_STATUS: rd_data = {30'h0, done_q[b], tg_busy_i[b]};
               default:   rd_data = '0;
            endcase
         end
      end
      if (rd_err) rd_data = '0;
   end

   // Data is captured from the pre-edge register state, so a write committing
   // on the same edge is not visible to this read.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rd_state_q <= R_IDLE;
         rdata_q    <= '0;
         rresp_q    <= RespOkay;
      end else begin
         case (rd_state_q)
            R_IDLE: begin
               if (axi_lite_req_i.ar_valid) begin
                  rdata_q    <= rd_data;
                  rresp_q    <= rd_err ? RespSlverr : RespOkay;
                  rd_state_q <= R_RESP;
               end
            end
            R_RESP: begin
               if (axi_lite_req_i.r_ready) rd_state_q <= R_IDLE;
            end
            default: rd_state_q <= R_IDLE;
         endcase
      end
   end

   // -------------------------------------------------------------- outputs
   always_comb begin
      axi_lite_rsp_o          = '0;
      axi_lite_rsp_o.aw_ready = (wr_state_q == W_IDLE) && !aw_held_q;
      axi_lite_rsp_o.w_ready  = (wr_state_q == W_IDLE) && !w_held_q;
      axi_lite_rsp_o.b_valid  = (wr_state_q == W_RESP);
      axi_lite_rsp_o.b_resp   = bresp_q;
      axi_lite_rsp_o.ar_ready = (rd_state_q == R_IDLE);
      axi_lite_rsp_o.r_valid  = (rd_state_q == R_RESP);
      axi_lite_rsp_o.r_data   = rdata_q;
      axi_lite_rsp_o.r_resp   = rresp_q;
   end

   assign tg_cfg_o   = cfg_q;
   assign tg_start_o = start_q;

   // Address bits outside the bank index / word offset are don't-care.
   logic unused_addr_bits;
   assign unused_addr_bits = ^{wr_addr[1:0], wr_addr[31:OffW+IdxW],
                               axi_lite_req_i.ar_addr[1:0],
                               axi_lite_req_i.ar_addr[31:OffW+IdxW]};

endmodule

// File: tb/tb_fpga_tg_cfg_regfile.sv
// Bench for fpga_tg_cfg_regfile: directed scenario tasks plus a response
// scoreboard that pops expected {resp,data} entries as B/R beats complete.
module tb_fpga_tg_cfg_regfile;
  import fpga_picobello_pkg::*;

  localparam int N = 3;

  logic clk = 1'b0;
  logic rst;
  axi_lite_host_req_t req;
  axi_lite_host_rsp_t rsp;
  tg_cfg_t [N-1:0] cfg;
  logic [N-1:0] start, busy, done;

  logic [33:0] exp_q[$];   // {rresp, rdata}
  logic [1:0]  expb_q[$];  // bresp
  logic [33:0] mon_r;
  logic [1:0]  mon_b;
  int total = 0;
  int bad = 0;
  int start_cycles = 0;
  logic [N-1:0] start_seen = '0;
  logic [31:0] model [N][4];

  fpga_tg_cfg_regfile dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .axi_lite_req_i (req),
    .axi_lite_rsp_o (rsp),
    .tg_cfg_o       (cfg),
    .tg_start_o     (start),
    .tg_busy_i      (busy),
    .tg_done_i      (done)
  );

  // ---------------------------------------------------------- clock/reset
  always #5 clk = ~clk;

  // ------------------------------------------------------------ monitors
  always @(negedge clk) begin
    if (start != '0) begin
      start_cycles = start_cycles + 1;
      start_seen   = start_seen | start;
    end
    if (!rst && rsp.r_valid && req.r_ready) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h", {rsp.r_resp, rsp.r_data});
      end else begin
        mon_r = exp_q.pop_front();
        if ({rsp.r_resp, rsp.r_data} !== mon_r) begin
          bad++;
          $display("FAIL rd_beat got=%h exp=%h", {rsp.r_resp, rsp.r_data}, mon_r);
        end
      end
    end
    if (!rst && rsp.b_valid && req.b_ready) begin
      total++;
      if (expb_q.size() == 0) begin
        bad++;
        $display("FAIL b_unexpected got=%b", rsp.b_resp);
      end else begin
        mon_b = expb_q.pop_front();
        if (rsp.b_resp !== mon_b) begin
          bad++;
          $display("FAIL b_beat got=%b exp=%b", rsp.b_resp, mon_b);
        end
      end
    end
  end

  function automatic logic [31:0] addr_of(input int b, input logic [31:0] off);
    return 32'(b) * 32'h40 + off;
  endfunction

  // -------------------------------------------------------------- drivers
  // All drivers start and end 1 time unit after a rising edge.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    logic awr, wr;
    req.aw_addr = a; req.aw_valid = 1'b1;
    req.w_data = d; req.w_strb = s; req.w_valid = 1'b1;
    req.b_ready = 1'b1;
    n = 0;
    while ((req.aw_valid || req.w_valid) && n < 20) begin
      awr = rsp.aw_ready; wr = rsp.w_ready;
      @(posedge clk); #1;
      if (awr) req.aw_valid = 1'b0;
      if (wr) req.w_valid = 1'b0;
      n++;
    end
    while (!rsp.b_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL wr_timeout addr=%h got=no_bvalid exp=bvalid", a);
      req.aw_valid = 1'b0; req.w_valid = 1'b0;
    end
    @(posedge clk); #1;
    req.b_ready = 1'b0;
  endtask

  task automatic axi_read(input logic [31:0] a);
    int n;
    logic arr;
    req.ar_addr = a; req.ar_valid = 1'b1; req.r_ready = 1'b1;
    n = 0;
    while (req.ar_valid && n < 20) begin
      arr = rsp.ar_ready;
      @(posedge clk); #1;
      if (arr) req.ar_valid = 1'b0;
      n++;
    end
    while (!rsp.r_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) begin
      total++; bad++;
      $display("FAIL rd_timeout addr=%h got=no_rvalid exp=rvalid", a);
      req.ar_valid = 1'b0;
    end
    @(posedge clk); #1;
    req.r_ready = 1'b0;
  endtask

  // ---------------------------------------------------------------- tests
  task automatic test_reset();
    rst = 1'b1; req = '0; busy = '0; done = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    total++;
    if (cfg !== '0) begin bad++; $display("FAIL reset_cfg got=%h exp=0", cfg); end
    total++;
    if (start !== '0) begin bad++; $display("FAIL reset_start got=%b exp=0", start); end
    total++;
    if ({rsp.b_valid, rsp.r_valid} !== 2'b00) begin
      bad++; $display("FAIL reset_valids got=%b exp=00", {rsp.b_valid, rsp.r_valid});
    end
    total++;
    if ({rsp.aw_ready, rsp.w_ready, rsp.ar_ready} !== 3'b111) begin
      bad++; $display("FAIL reset_readys got=%b exp=111", {rsp.aw_ready, rsp.w_ready, rsp.ar_ready});
    end
    exp_q.push_back({2'b00, 32'h0});
    axi_read(addr_of(0, 32'h34));
  endtask

  task automatic test_basic_rw();
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h00), 32'h0000_0021, 4'hF);
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h08), 32'hDEAD_BEEF, 4'hF);
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h0C), 32'h0000_0001, 4'hF);
    total++;
    if ({cfg[0].mem_port_id, cfg[0].traffic_gen_port_id} !== 8'h21) begin
      bad++; $display("FAIL basic_ports got=%h exp=21", {cfg[0].mem_port_id, cfg[0].traffic_gen_port_id});
    end
    total++;
    if (cfg[0].traffic_gen_addr_base !== 64'h1_DEAD_BEEF) begin
      bad++; $display("FAIL basic_tg_base got=%h exp=1deadbeef", cfg[0].traffic_gen_addr_base);
    end
    exp_q.push_back({2'b00, 32'h0000_0021}); axi_read(addr_of(0, 32'h00));
    exp_q.push_back({2'b00, 32'hDEAD_BEEF}); axi_read(addr_of(0, 32'h08));
    exp_q.push_back({2'b00, 32'h0000_0001}); axi_read(addr_of(0, 32'h0C));
    // byte strobes and ignored PORT_IDS upper bits
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h08), 32'h0055_AA00, 4'b0010);
    total++;
    if (cfg[0].traffic_gen_addr_base !== 64'h1_DEAD_AAEF) begin
      bad++; $display("FAIL strb_tg_base got=%h exp=1deadaaef", cfg[0].traffic_gen_addr_base);
    end
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h00), 32'hFFFF_FF43, 4'hF);
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h00), 32'h0000_0099, 4'b1110);
    exp_q.push_back({2'b00, 32'h0000_0043}); axi_read(addr_of(0, 32'h00));
  endtask

  task automatic test_order();
    expb_q.push_back(2'b00); expb_q.push_back(2'b00);
    req.b_ready = 1'b0;
    req.w_data = 32'h1111_2222; req.w_strb = 4'hF; req.w_valid = 1'b1;
    @(posedge clk); #1;
    req.w_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      total++;
      if ({rsp.aw_ready, rsp.w_ready, rsp.b_valid} !== 3'b100) begin
        bad++; $display("FAIL w_first_wait%0d got=%b exp=100", i, {rsp.aw_ready, rsp.w_ready, rsp.b_valid});
      end
      @(posedge clk); #1;
    end
    req.aw_addr = addr_of(1, 32'h10); req.aw_valid = 1'b1;
    @(posedge clk); #1;
    req.aw_valid = 1'b0;
    total++;
    if ({rsp.b_valid, rsp.b_resp, cfg[1].mem_addr_base} !== {3'b100, 64'h1111_2222}) begin
      bad++; $display("FAIL w_first_commit got=%h exp=%h", {rsp.b_valid, rsp.b_resp, cfg[1].mem_addr_base}, {3'b100, 64'h1111_2222});
    end
    // new AW/W offered while the first response is stalled
    req.aw_addr = addr_of(1, 32'h14); req.aw_valid = 1'b1;
    req.w_data = 32'h3333_4444; req.w_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({rsp.aw_ready, rsp.w_ready, rsp.b_valid, cfg[1].mem_addr_base[63:32]} !== {3'b001, 32'h0}) begin
        bad++; $display("FAIL bresp_hold%0d got=%b/%h exp=001/0", i, {rsp.aw_ready, rsp.w_ready, rsp.b_valid}, cfg[1].mem_addr_base[63:32]);
      end
      @(posedge clk); #1;
    end
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    total++;
    if ({rsp.aw_ready, rsp.w_ready, rsp.b_valid} !== 3'b110) begin
      bad++; $display("FAIL after_b_idle got=%b exp=110", {rsp.aw_ready, rsp.w_ready, rsp.b_valid});
    end
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    total++;
    if ({rsp.b_valid, cfg[1].mem_addr_base} !== {1'b1, 64'h3333_4444_1111_2222}) begin
      bad++; $display("FAIL second_commit got=%h exp=%h", {rsp.b_valid, cfg[1].mem_addr_base}, {1'b1, 64'h3333_4444_1111_2222});
    end
    req.b_ready = 1'b1;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    total++;
    if (rsp.b_valid !== 1'b0) begin bad++; $display("FAIL b_drop got=%b exp=0", rsp.b_valid); end
  endtask

  task automatic test_start();
    done = 3'b100;
    @(posedge clk); #1;
    done = '0;
    exp_q.push_back({2'b00, 32'h2}); axi_read(addr_of(2, 32'h34));
    start_cycles = 0; start_seen = '0;
    expb_q.push_back(2'b00); axi_write(addr_of(2, 32'h30), 32'h1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (start_cycles !== 1 || start_seen !== 3'b100) begin
      bad++; $display("FAIL start_pulse got=%0d/%b exp=1/100", start_cycles, start_seen);
    end
    exp_q.push_back({2'b00, 32'h0}); axi_read(addr_of(2, 32'h34));
    exp_q.push_back({2'b00, 32'h0}); axi_read(addr_of(2, 32'h30));
  endtask

  task automatic test_busy();
    busy = 3'b010;
    start_cycles = 0; start_seen = '0;
    expb_q.push_back(2'b10); axi_write(addr_of(1, 32'h28), 32'hCAFE_F00D, 4'hF);
    expb_q.push_back(2'b10); axi_write(addr_of(1, 32'h30), 32'h1, 4'hF);
    repeat (2) @(posedge clk);
    #1;
    total++;
    if (cfg[1].idx !== 64'h0) begin bad++; $display("FAIL busy_idx got=%h exp=0", cfg[1].idx); end
    total++;
    if (start_cycles !== 0) begin bad++; $display("FAIL busy_start got=%0d exp=0", start_cycles); end
    exp_q.push_back({2'b00, 32'h1}); axi_read(addr_of(1, 32'h34));
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h28), 32'h1234_5678, 4'hF);
    total++;
    if (cfg[0].idx !== 64'h1234_5678) begin bad++; $display("FAIL other_bank_idx got=%h exp=12345678", cfg[0].idx); end
    busy = '0;
  endtask

  task automatic test_done_w1c();
    expb_q.push_back(2'b00);
    req.aw_addr = addr_of(0, 32'h34); req.aw_valid = 1'b1;
    req.w_data = 32'h2; req.w_strb = 4'hF; req.w_valid = 1'b1;
    req.b_ready = 1'b1; done = 3'b001;
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0; done = '0;
    @(posedge clk); #1;
    req.b_ready = 1'b0;
    exp_q.push_back({2'b00, 32'h2}); axi_read(addr_of(0, 32'h34));
    expb_q.push_back(2'b00); axi_write(addr_of(0, 32'h34), 32'h2, 4'hF);
    exp_q.push_back({2'b00, 32'h0}); axi_read(addr_of(0, 32'h34));
  endtask

  task automatic test_random();
    logic [31:0] d, m;
    logic [3:0] s;
    int b, r;
    for (int i = 0; i < N; i++) for (int j = 0; j < 4; j++) model[i][j] = 32'h0;
    for (int k = 0; k < 24; k++) begin
      b = $urandom_range(0, N - 1);
      r = $urandom_range(0, 3);
      d = $urandom();
      s = 4'($urandom_range(0, 15));
      m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      expb_q.push_back(2'b00);
      axi_write(addr_of(b, 32'h18 + 32'(r) * 4), d, s);
      model[b][r] = (model[b][r] & ~m) | (d & m);
    end
    for (int i = 0; i < N; i++) begin
      total++;
      if ({cfg[i].compute_dim, cfg[i].traffic_dim} !== {model[i][3], model[i][2], model[i][1], model[i][0]}) begin
        bad++; $display("FAIL rand_cfg%0d got=%h exp=%h", i, {cfg[i].compute_dim, cfg[i].traffic_dim}, {model[i][3], model[i][2], model[i][1], model[i][0]});
      end
      for (int j = 0; j < 4; j++) begin
        exp_q.push_back({2'b00, model[i][j]});
        axi_read(addr_of(i, 32'h18 + 32'(j) * 4));
      end
    end
  endtask

  task automatic test_errors_and_reset();
    exp_q.push_back({2'b10, 32'h0}); axi_read(addr_of(N, 32'h00));
    exp_q.push_back({2'b10, 32'h0}); axi_read(addr_of(0, 32'h38));
    exp_q.push_back({2'b10, 32'h0}); axi_read(addr_of(0, 32'h04));
    expb_q.push_back(2'b10); axi_write(addr_of(0, 32'h38), 32'hFFFF_FFFF, 4'hF);
    expb_q.push_back(2'b10); axi_write(addr_of(N, 32'h08), 32'hFFFF_FFFF, 4'hF);
    req.aw_addr = addr_of(0, 32'h00); req.aw_valid = 1'b1;
    req.w_data = 32'h0000_0055; req.w_strb = 4'hF; req.w_valid = 1'b1;
    req.b_ready = 1'b0;
    @(posedge clk); #1;
    req.aw_valid = 1'b0; req.w_valid = 1'b0;
    total++;
    if ({rsp.b_valid, cfg[0].mem_port_id} !== 5'h15) begin
      bad++; $display("FAIL pre_reset got=%h exp=15", {rsp.b_valid, cfg[0].mem_port_id});
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (rsp.b_valid !== 1'b0) begin bad++; $display("FAIL reset_bvalid got=%b exp=0", rsp.b_valid); end
    total++;
    if (cfg !== '0) begin bad++; $display("FAIL reset_cfg_mid got=%h exp=0", cfg); end
    total++;
    if ({rsp.aw_ready, rsp.w_ready} !== 2'b11) begin
      bad++; $display("FAIL reset_idle got=%b exp=11", {rsp.aw_ready, rsp.w_ready});
    end
  endtask

  // ---------------------------------------------------------------- main
  initial begin
    test_reset();
    test_basic_rw();
    test_order();
    test_start();
    test_busy();
    test_done_w1c();
    test_random();
    test_errors_and_reset();
    repeat (2) @(posedge clk);
    total++;
    if (exp_q.size() != 0 || expb_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain got=%0d/%0d exp=0/0", exp_q.size(), expb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
